// File: rtl/instr_mem_pkg.sv
// Shared types and widths for the instruction memory responder.
package instr_mem_pkg;

  localparam int WORD_W = 32;
  localparam int ADR_W  = 32;

  // Grant FSM: IDLE (no request), WAIT (request held, wait not elapsed),
  // READY (wait elapsed, grant pending on capacity).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } gnt_state_e;

endpackage

// File: rtl/instr_mem_responder_if.sv
// Instruction fetch bus: request/grant handshake plus in-order read response.
interface instr_mem_responder_if;
  import instr_mem_pkg::*;

  logic              instr_req;
  logic [ADR_W-1:0]  instr_adr;
  logic              instr_gnt;
  logic              instr_rvalid;
  logic [WORD_W-1:0] instr_read;

  // Fetch initiator (core side).
  modport master (
    output instr_req,
    output instr_adr,
    input  instr_gnt,
    input  instr_rvalid,
    input  instr_read
  );

  // Memory responder side.
  modport slave (
    input  instr_req,
    input  instr_adr,
    output instr_gnt,
    output instr_rvalid,
    output instr_read
  );

endinterface

// File: rtl/resp_pipe.sv
// Fixed-latency valid/data delay line; valids clear asynchronously on reset,
// data is only meaningful alongside its valid and reads as zero otherwise.
module resp_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  // Valid shift register; reset drops every in-flight response.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Data shift register, no reset needed since output is gated by valid.
  always_ff @(posedge clk) begin
    dat_q[0] <= in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = out_valid ? dat_q[DEPTH-1] : '0;

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: configurable grant wait, fixed read latency,
// bounded outstanding requests, in-order responses, preload write port.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int LOG_DEPTH       = 10,
  parameter int GNT_WAIT        = 1,
  parameter int RD_LATENCY      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 res,
  instr_mem_responder_if.slave fetch,
  input  logic                 load_we,
  input  logic [ADR_W-1:0]     load_adr,
  input  logic [WORD_W-1:0]    load_data
);

  localparam int DEPTH  = 1 << LOG_DEPTH;
  localparam int WAIT_W = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [WAIT_W-1:0] WAIT_DONE = WAIT_W'(GNT_WAIT);
  localparam logic [OUT_W-1:0]  OUT_LIMIT = OUT_W'(MAX_OUTSTANDING);

  logic [WORD_W-1:0]    mem [DEPTH];

  gnt_state_e           state_q, state_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;

  logic [LOG_DEPTH-1:0] fetch_idx;
  logic [LOG_DEPTH-1:0] load_idx;
  logic                 have_room;
  logic                 gnt;
  logic                 handshake;
  logic                 rvalid;
  logic [WORD_W-1:0]    rd_word;
  logic [WORD_W-1:0]    rd_data;
  logic                 unused_adr_bits;

  // Word index drops the byte offset; upper bits alias modulo depth.
  assign fetch_idx = fetch.instr_adr[LOG_DEPTH+1:2];
  assign load_idx  = load_adr[LOG_DEPTH+1:2];
  assign unused_adr_bits = ^{fetch.instr_adr[ADR_W-1:LOG_DEPTH+2], fetch.instr_adr[1:0],
                             load_adr[ADR_W-1:LOG_DEPTH+2], load_adr[1:0]};

  // A retiring response frees its slot in the same cycle, so a full pipe can
  // still accept one new request while rvalid is high.
  assign have_room = (outstanding_q < OUT_LIMIT) | rvalid;

  // Reset gates the grant directly: with GNT_WAIT=0 the cleared wait counter
  // would otherwise permit a grant while reset is still asserted.
  assign gnt       = ~res & fetch.instr_req & (wait_cnt_q == WAIT_DONE) & have_room;
  assign handshake = fetch.instr_req & gnt;

  // Memory is read in the handshake cycle; a same-cycle preload write lands
  // at the clock edge, so the fetch sees the previous contents.
  assign rd_word = mem[fetch_idx];

  // Preload write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_idx] <= load_data;
    end
  end

  // Next-state, grant wait counter and outstanding counter.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    outstanding_d = outstanding_q;

    if (!fetch.instr_req || handshake) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_DONE) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (fetch.instr_req && !handshake) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!fetch.instr_req || handshake) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == WAIT_DONE) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (!fetch.instr_req || handshake) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    unique case ({handshake, rvalid})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  resp_pipe #(
    .DEPTH (RD_LATENCY),
    .WIDTH (WORD_W)
  ) u_resp_pipe (
    .clk       (clk),
    .res       (res),
    .in_valid  (handshake),
    .in_data   (rd_word),
    .out_valid (rvalid),
    .out_data  (rd_data)
  );

  assign fetch.instr_gnt    = gnt;
  assign fetch.instr_rvalid = rvalid;
  assign fetch.instr_read   = rd_data;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three configurations checked every cycle
// against a queue-based reference model, plus directed corner cases.
module tb_instr_mem_responder;

  logic clk;
  logic res;

  logic        req_a  [3];
  logic [31:0] adr    [3];
  logic        gnt_a  [3];
  logic        rv_a   [3];
  logic [31:0] rd_a   [3];
  logic        we_a   [3];
  logic [31:0] ladr   [3];
  logic [31:0] ldata  [3];

  int n_cmp;
  int n_bad;

  // Reference model state: memory image, pending responses, wait tracking.
  logic [31:0] mem_m  [3][1024];
  int unsigned due_m  [3][8];
  logic [31:0] dat_m  [3][8];
  logic [2:0]  hd_m   [3];
  int unsigned cnt_m  [3];
  int unsigned held_m [3];
  int unsigned cyc;
  int          obs_out2;
  int          max_out2;
  logic [31:0] word0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_mem_responder_if bus0 ();
  instr_mem_responder_if bus1 ();
  instr_mem_responder_if bus2 ();

  assign bus0.instr_req = req_a[0];
  assign bus0.instr_adr = adr[0];
  assign gnt_a[0]       = bus0.instr_gnt;
  assign rv_a[0]        = bus0.instr_rvalid;
  assign rd_a[0]        = bus0.instr_read;
  assign bus1.instr_req = req_a[1];
  assign bus1.instr_adr = adr[1];
  assign gnt_a[1]       = bus1.instr_gnt;
  assign rv_a[1]        = bus1.instr_rvalid;
  assign rd_a[1]        = bus1.instr_read;
  assign bus2.instr_req = req_a[2];
  assign bus2.instr_adr = adr[2];
  assign gnt_a[2]       = bus2.instr_gnt;
  assign rv_a[2]        = bus2.instr_rvalid;
  assign rd_a[2]        = bus2.instr_read;

  instr_mem_responder #(
    .LOG_DEPTH(10), .GNT_WAIT(1), .RD_LATENCY(2), .MAX_OUTSTANDING(2)
  ) dut0 (
    .clk(clk), .res(res), .fetch(bus0.slave),
    .load_we(we_a[0]), .load_adr(ladr[0]), .load_data(ldata[0])
  );

  instr_mem_responder #(
    .LOG_DEPTH(10), .GNT_WAIT(0), .RD_LATENCY(2), .MAX_OUTSTANDING(2)
  ) dut1 (
    .clk(clk), .res(res), .fetch(bus1.slave),
    .load_we(we_a[1]), .load_adr(ladr[1]), .load_data(ldata[1])
  );

  instr_mem_responder #(
    .LOG_DEPTH(10), .GNT_WAIT(0), .RD_LATENCY(3), .MAX_OUTSTANDING(1)
  ) dut2 (
    .clk(clk), .res(res), .fetch(bus2.slave),
    .load_we(we_a[2]), .load_adr(ladr[2]), .load_data(ldata[2])
  );

  function automatic int unsigned gw_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int unsigned lat_of(input int k);
    return (k == 2) ? 3 : 2;
  endfunction

  function automatic int unsigned mo_of(input int k);
    return (k == 2) ? 1 : 2;
  endfunction

  function automatic logic [9:0] widx(input logic [31:0] a);
    return 10'((a >> 2) % 1024);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle of the reference: a pending response is due exactly LAT cycles
  // after its grant; a grant needs the request held GNT_WAIT cycles and
  // either a free slot or a response retiring now.
  task automatic model_step(input int k);
    logic        exp_rv;
    logic        exp_gnt;
    logic [31:0] exp_rd;
    logic [2:0]  slot;
    if (res) begin
      check($sformatf("rst_gnt%0d", k), 32'(gnt_a[k]), 32'(0));
      check($sformatf("rst_rv%0d", k), 32'(rv_a[k]), 32'(0));
      check($sformatf("rst_rd%0d", k), rd_a[k], 32'(0));
      cnt_m[k]  = 0;
      hd_m[k]   = 3'd0;
      held_m[k] = 0;
    end else begin
      exp_rv  = (cnt_m[k] != 0) && (due_m[k][hd_m[k]] == cyc);
      exp_gnt = req_a[k] && (held_m[k] >= gw_of(k)) && ((cnt_m[k] < mo_of(k)) || exp_rv);
      exp_rd  = exp_rv ? dat_m[k][hd_m[k]] : 32'h0;
      check($sformatf("gnt%0d", k), 32'(gnt_a[k]), 32'(exp_gnt));
      check($sformatf("rvalid%0d", k), 32'(rv_a[k]), 32'(exp_rv));
      check($sformatf("read%0d", k), rd_a[k], exp_rd);
      if (exp_rv) begin
        hd_m[k]  = hd_m[k] + 3'd1;
        cnt_m[k] = cnt_m[k] - 1;
      end
      if (exp_gnt) begin
        slot = hd_m[k] + 3'(cnt_m[k]);
        due_m[k][slot] = cyc + lat_of(k);
        dat_m[k][slot] = mem_m[k][widx(adr[k])];
        cnt_m[k] = cnt_m[k] + 1;
      end
      held_m[k] = (!req_a[k] || exp_gnt) ? 0 : held_m[k] + 1;
    end
    if (we_a[k]) begin
      mem_m[k][widx(ladr[k])] = ldata[k];
    end
  endtask

  // Sample away from the active edge; also track dut2 occupancy from its pins.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      model_step(k);
    end
    if (res) begin
      obs_out2 = 0;
    end else begin
      if (req_a[2] && gnt_a[2]) obs_out2++;
      if (rv_a[2]) obs_out2--;
      if (obs_out2 > max_out2) max_out2 = obs_out2;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input int n);
    req_a[k] = 1'b0;
    repeat (n) tick();
  endtask

  // Hold a request until granted; w = cycles spent waiting. Leaves req high.
  task automatic fetch(input int k, input logic [31:0] a, output int w);
    req_a[k] = 1'b1;
    adr[k]   = a;
    w = 0;
    forever begin
      @(negedge clk);
      if (gnt_a[k]) break;
      w++;
      if (w >= 40) begin
        check($sformatf("gnt_timeout%0d", k), 32'(gnt_a[k]), 32'(1));
        break;
      end
      tick();
    end
    tick();
  endtask

  // Wait (bounded) for the next response; c = cycles counted from the call.
  task automatic wait_rv(input int k, output logic [31:0] d, output int c);
    c = 0;
    d = '0;
    repeat (16) begin
      @(negedge clk);
      c++;
      if (rv_a[k]) begin
        d = rd_a[k];
        break;
      end
    end
    tick();
  endtask

  task automatic rand_traffic(input int k);
    int w_unused;
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) begin
        req_a[k] = 1'b0;
        we_a[k]  = 1'b1;
        ladr[k]  = $urandom;
        ldata[k] = $urandom;
        tick();
        we_a[k]  = 1'b0;
      end
      fetch(k, $urandom, w_unused);
      if ($urandom_range(0, 2) == 0) idle(k, int'($urandom_range(1, 3)));
    end
    req_a[k] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int c, w, w0, w1, w2, n;

    res = 1'b1;
    cyc = 0;
    obs_out2 = 0;
    max_out2 = 0;
    word0 = '0;
    for (int k = 0; k < 3; k++) begin
      req_a[k] = 1'b0; adr[k] = '0; we_a[k] = 1'b0; ladr[k] = '0; ldata[k] = '0;
      hd_m[k] = 3'd0; cnt_m[k] = 0; held_m[k] = 0;
    end

    // Reset holds grant low even with a request on a zero-wait instance.
    repeat (2) @(posedge clk);
    #1;
    req_a[1] = 1'b1;
    #1;
    check("rst_hold_gnt1", 32'(gnt_a[1]), 32'(0));
    check("rst_hold_rv1", 32'(rv_a[1]), 32'(0));
    check("rst_hold_rd1", rd_a[1], 32'(0));
    req_a[1] = 1'b0;
    tick();
    res = 1'b0;

    // Preload every word, with junk in the ignored address bits.
    for (int i = 0; i < 1024; i++) begin
      for (int k = 0; k < 3; k++) begin
        we_a[k]  = 1'b1;
        ladr[k]  = ($urandom & 32'hFFFF_F003) | 32'(i << 2);
        ldata[k] = $urandom;
      end
      if (i == 3) ldata[0] = 32'h1111_1111;
      if (i == 5) ldata[0] = 32'h0050_0093;
      if (i == 0) word0 = ldata[0];
      tick();
    end
    for (int k = 0; k < 3; k++) we_a[k] = 1'b0;
    tick();

    // Default config: one wait cycle, two-cycle read latency.
    fetch(0, 32'h14, w);
    req_a[0] = 1'b0;
    check("gnt_wait_w5", 32'(w), 32'(1));
    wait_rv(0, d, c);
    check("rv_lat_w5", 32'(c), 32'(2));
    check("read_w5", d, 32'h0050_0093);

    // Zero wait: three back-to-back grants, the third on a retiring response.
    fetch(1, 32'h0, w0);
    fetch(1, 32'h4, w1);
    fetch(1, 32'h8, w2);
    req_a[1] = 1'b0;
    check("b2b_w0", 32'(w0), 32'(0));
    check("b2b_w1", 32'(w1), 32'(0));
    check("b2b_w2", 32'(w2), 32'(0));
    idle(1, 6);

    // Single outstanding, latency 3: each later grant waits for the retire.
    for (int i = 0; i < 8; i++) begin
      fetch(2, $urandom, w);
      check($sformatf("cap1_wait%0d", i), 32'(w), (i == 0) ? 32'(0) : 32'(2));
    end
    req_a[2] = 1'b0;
    idle(2, 6);

    // Preload write and fetch to the same word in the same cycle.
    req_a[0] = 1'b1;
    adr[0]   = 32'hC;
    @(negedge clk);
    check("wr_rd_pre_gnt", 32'(gnt_a[0]), 32'(0));
    tick();
    we_a[0]  = 1'b1;
    ladr[0]  = 32'hC;
    ldata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_rd_gnt", 32'(gnt_a[0]), 32'(1));
    tick();
    we_a[0]  = 1'b0;
    req_a[0] = 1'b0;
    wait_rv(0, d, c);
    check("wr_rd_lat", 32'(c), 32'(2));
    check("wr_rd_old", d, 32'h1111_1111);
    fetch(0, 32'hC, w);
    req_a[0] = 1'b0;
    wait_rv(0, d, c);
    check("wr_rd_new", d, 32'hDEAD_BEEF);

    // Address beyond depth aliases onto word 0.
    fetch(0, 32'h1000, w);
    req_a[0] = 1'b0;
    wait_rv(0, d, c);
    check("alias_w0", d, word0);

    // Reset one cycle after a handshake discards the in-flight request.
    fetch(1, 32'h0, w);
    check("pre_rst_gnt1", 32'(gnt_a[1]), 32'(1));
    res = 1'b1;
    #1;
    check("async_gnt1", 32'(gnt_a[1]), 32'(0));
    check("async_rv1", 32'(rv_a[1]), 32'(0));
    check("async_rd1", rd_a[1], 32'(0));
    tick();
    res = 1'b0;
    req_a[1] = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv_a[1]) n++;
    end
    tick();
    check("rst_discard", 32'(n), 32'(0));

    // Randomised traffic on all three configurations at once.
    fork
      rand_traffic(0);
      rand_traffic(1);
      rand_traffic(2);
    join
    repeat (10) tick();

    check("outst_le1", 32'(max_out2 <= 1), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
